// File: rtl/pio_master_pkg.sv
// pio_master_pkg
// Shared definitions for the PIO Avalon-MM initiator and its helpers.
//   state_t          : transaction FSM states
//   MAX_READ_LATENCY : largest fixed read latency the initiator can wait out
//   timeout_w()      : counter width able to hold a stall limit value
package pio_master_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      WAIT_RD = 2'd2,
      RESP    = 2'd3
   } state_t;

   localparam int MAX_READ_LATENCY = 7;

   // Width of a counter that must be able to reach 'limit' without wrapping.
   // A limit below 1 is illegal; returning 1 keeps the elaboration sane so
   // the parameter check in the top can report it.
   function automatic int timeout_w(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/pio_master_stall_timer.sv
// pio_master_stall_timer
// Counts consecutive stall cycles for a bus initiator and flags when the
// stall limit is hit, so the initiator can abandon the access.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   clear    : restart the count from zero (wins over enable)
//   enable   : a stall cycle is happening now
//   expired  : this stall cycle is the LIMIT-th consecutive one
module pio_master_stall_timer
   import pio_master_pkg::*;
#(
   parameter int LIMIT = 255,
   parameter int CNT_W = timeout_w(LIMIT)
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [CNT_W-1:0] count;

   // Stall count: zeroed on clear, advanced once per stalled cycle. No
   // saturation is needed because the owner aborts once expired fires.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CNT_W'(1);
      end
   end

   // The count holds the number of earlier stall cycles, so reaching
   // LIMIT-1 during a stall means this is the LIMIT-th one.
   assign expired = enable && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/pio_avalon_master.sv
// pio_avalon_master
// Avalon-MM initiator issuing one read or write at a time to a
// register-mapped slave (e.g. a PIO port), driven by a local
// command/response handshake.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     : command handshake (ready only while idle)
//   cmd_write               : 1 = write, 0 = read
//   cmd_address/cmd_wdata   : target word address and write data
//   rsp_valid/rsp_ready     : response handshake
//   rsp_rdata               : read data (0 for writes and timeouts)
//   rsp_error               : 1 = access abandoned after stall timeout
//   address, chipselect,
//   write_n, read_n,
//   writedata               : registered Avalon initiator outputs
//   readdata, waitrequest   : Avalon slave inputs
module pio_avalon_master
   import pio_master_pkg::*;
#(
   parameter int ADDR_W       = 2,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 0,
   parameter int TIMEOUT      = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_address,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_error,
   output logic [ADDR_W-1:0] address,
   output logic              chipselect,
   output logic              write_n,
   output logic              read_n,
   output logic [DATA_W-1:0] writedata,
   input  logic [DATA_W-1:0] readdata,
   input  logic              waitrequest
);

   // Out-of-range parameters stop elaboration with a readable message.
   if (READ_LATENCY < 0 || READ_LATENCY > MAX_READ_LATENCY ||
       TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
      $error("pio_avalon_master: invalid READ_LATENCY=%0d or TIMEOUT=%0d",
             READ_LATENCY, TIMEOUT);
   end

   // The latency counter counts down to zero, so it is loaded with one
   // less than the latency (the accept cycle itself is the first one).
   localparam logic [2:0] LAT_LOAD =
      (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;

   state_t     state;
   logic       wr_q;
   logic [2:0] lat_cnt;
   logic       stall_clear;
   logic       stall_enable;
   logic       stall_expired;

   assign cmd_ready    = (state == IDLE);
   assign stall_clear  = (state == IDLE);
   assign stall_enable = (state == ACCESS) && waitrequest;

   pio_master_stall_timer #(
      .LIMIT (TIMEOUT),
      .CNT_W (timeout_w(TIMEOUT))
   ) u_stall_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (stall_clear),
      .enable  (stall_enable),
      .expired (stall_expired)
   );

   // Transaction FSM. All bus and response outputs are registered here so
   // the slave and the consumer never see combinational glitches; strobes
   // are raised on acceptance and dropped on the cycle after the slave
   // accepts (or the stall limit is reached). address/writedata keep their
   // last value between accesses.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         wr_q       <= 1'b0;
         lat_cnt    <= '0;
         address    <= '0;
         writedata  <= '0;
         chipselect <= 1'b0;
         write_n    <= 1'b1;
         read_n     <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_error  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  wr_q       <= cmd_write;
                  address    <= cmd_address;
                  writedata  <= cmd_wdata;
                  chipselect <= 1'b1;
                  write_n    <= ~cmd_write;
                  read_n     <= cmd_write;
                  state      <= ACCESS;
               end
            end

            ACCESS: begin
               if (waitrequest) begin
                  if (stall_expired) begin
                     chipselect <= 1'b0;
                     write_n    <= 1'b1;
                     read_n     <= 1'b1;
                     rsp_valid  <= 1'b1;
                     rsp_rdata  <= '0;
                     rsp_error  <= 1'b1;
                     state      <= RESP;
                  end
               end else begin
                  chipselect <= 1'b0;
                  write_n    <= 1'b1;
                  read_n     <= 1'b1;
                  rsp_error  <= 1'b0;
                  if (wr_q) begin
                     rsp_valid <= 1'b1;
                     rsp_rdata <= '0;
                     state     <= RESP;
                  end else if (READ_LATENCY == 0) begin
                     rsp_valid <= 1'b1;
                     rsp_rdata <= readdata;
                     state     <= RESP;
                  end else begin
                     lat_cnt   <= LAT_LOAD;
                     state     <= WAIT_RD;
                  end
               end
            end

            WAIT_RD: begin
               if (lat_cnt == 3'd0) begin
                  rsp_valid <= 1'b1;
                  rsp_rdata <= readdata;
                  rsp_error <= 1'b0;
                  state     <= RESP;
               end else begin
                  lat_cnt <= lat_cnt - 3'd1;
               end
            end

            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pio_avalon_master.sv
// tb_pio_avalon_master
// Directed self-checking bench. dut0 (READ_LATENCY=0, TIMEOUT=8) talks to a
// PIO-style slave model with one data register at address 0; dut2
// (READ_LATENCY=2, TIMEOUT=8) is fed hand-driven readdata to check the
// latency capture point. Cycle 0 of each scenario is the cycle in which the
// command is presented; inputs change 1 time unit after posedge, outputs are
// sampled on negedge.
module tb_pio_avalon_master;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid, cmd_write, rsp_ready, waitrequest;
   logic [1:0]  cmd_address;
   logic [31:0] cmd_wdata;

   logic        cmd_ready, rsp_valid, rsp_error, chipselect, write_n, read_n;
   logic [31:0] rsp_rdata, writedata, readdata;
   logic [1:0]  address;

   logic        cmd_valid2, waitrequest2;
   logic        cmd_ready2, rsp_valid2, rsp_error2, chipselect2, write_n2, read_n2;
   logic [31:0] rsp_rdata2, writedata2, readdata2;
   logic [1:0]  address2;

   logic [31:0] pio_reg = 32'h0;
   int          write_count = 0;
   int          checks = 0;
   int          errors = 0;
   int          wc0;

   always #5 clk = ~clk;

   pio_avalon_master #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(0), .TIMEOUT(8)) dut0 (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_address(cmd_address), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_error(rsp_error),
      .address(address), .chipselect(chipselect), .write_n(write_n),
      .read_n(read_n), .writedata(writedata), .readdata(readdata),
      .waitrequest(waitrequest)
   );

   pio_avalon_master #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(2), .TIMEOUT(8)) dut2 (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_write(cmd_write),
      .cmd_address(cmd_address), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata2),
      .rsp_error(rsp_error2),
      .address(address2), .chipselect(chipselect2), .write_n(write_n2),
      .read_n(read_n2), .writedata(writedata2), .readdata(readdata2),
      .waitrequest(waitrequest2)
   );

   // PIO slave model: one data register at address 0, other addresses read
   // as zero; a write lands only on a cycle the slave is not stalling.
   always @(posedge clk) begin
      if (chipselect && !write_n && !waitrequest) begin
         write_count <= write_count + 1;
         if (address == 2'd0) pio_reg <= writedata;
      end
   end
   assign readdata = (address == 2'd0) ? pio_reg : 32'h0;

   task cyc;
      @(posedge clk);
      #1;
   endtask

   task test_reset;
      reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = 2'd0;
      cmd_wdata = 32'h0; rsp_ready = 1'b1; waitrequest = 1'b0;
      cmd_valid2 = 1'b0; waitrequest2 = 1'b0; readdata2 = 32'h0;
      #7;
      checks++;
      if ({chipselect, write_n, read_n, address, writedata, rsp_valid, rsp_error, rsp_rdata}
          !== {3'b011, 2'd0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
         errors++;
         $display("[TB] FAIL reset_dut0: got cs/wn/rn=%b%b%b addr=%0d wd=%h rv=%b re=%b rd=%h required 011 0 0 0 0 0",
                  chipselect, write_n, read_n, address, writedata, rsp_valid, rsp_error, rsp_rdata);
      end
      checks++;
      if ({chipselect2, write_n2, read_n2, rsp_valid2, rsp_rdata2} !== {3'b011, 1'b0, 32'h0}) begin
         errors++;
         $display("[TB] FAIL reset_dut2: got cs/wn/rn=%b%b%b rv=%b rd=%h required 011 0 0",
                  chipselect2, write_n2, read_n2, rsp_valid2, rsp_rdata2);
      end
      #5 reset_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({cmd_ready, cmd_ready2} !== 2'b11) begin
         errors++;
         $display("[TB] FAIL ready_after_reset: got %b%b required 11", cmd_ready, cmd_ready2);
      end
   endtask

   task test_write;
      wc0 = write_count;
      cyc; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 2'd0;
      cmd_wdata = 32'hDEADBEEF; rsp_ready = 1'b1; waitrequest = 1'b0;
      @(negedge clk);
      checks++;
      if ({cmd_ready, chipselect} !== 2'b10) begin
         errors++;
         $display("[TB] FAIL write_c0: got ready/cs=%b%b required 10", cmd_ready, chipselect);
      end
      cyc; cmd_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({chipselect, write_n, read_n, address, writedata, rsp_valid, cmd_ready}
          !== {3'b101, 2'd0, 32'hDEADBEEF, 2'b00}) begin
         errors++;
         $display("[TB] FAIL write_strobe: got cs/wn/rn=%b%b%b addr=%0d wd=%h rv=%b rdy=%b required 101 0 deadbeef 0 0",
                  chipselect, write_n, read_n, address, writedata, rsp_valid, cmd_ready);
      end
      cyc;
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_error, rsp_rdata, chipselect, write_n, read_n} !== {2'b10, 32'h0, 3'b011}) begin
         errors++;
         $display("[TB] FAIL write_rsp: got rv=%b re=%b rd=%h bus=%b%b%b required 1 0 0 011",
                  rsp_valid, rsp_error, rsp_rdata, chipselect, write_n, read_n);
      end
      checks++;
      if (pio_reg !== 32'hDEADBEEF || write_count != wc0 + 1) begin
         errors++;
         $display("[TB] FAIL write_landed: got reg=%h writes=%0d required deadbeef %0d",
                  pio_reg, write_count - wc0, 1);
      end
      cyc;
      @(negedge clk);
      checks++;
      if ({rsp_valid, cmd_ready} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL write_done: got rv/rdy=%b%b required 01", rsp_valid, cmd_ready);
      end
   endtask

   task test_read(input logic [1:0] a, input logic [31:0] exp);
      cyc; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = a; cmd_wdata = 32'h0;
      rsp_ready = 1'b1; waitrequest = 1'b0;
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL read_accept a=%0d: got ready=%b required 1", a, cmd_ready);
      end
      cyc; cmd_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({chipselect, write_n, read_n, address} !== {3'b110, a}) begin
         errors++;
         $display("[TB] FAIL read_strobe a=%0d: got cs/wn/rn=%b%b%b addr=%0d required 110 %0d",
                  a, chipselect, write_n, read_n, address, a);
      end
      cyc;
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_error, rsp_rdata, chipselect, write_n, read_n} !== {2'b10, exp, 3'b011}) begin
         errors++;
         $display("[TB] FAIL read_rsp a=%0d: got rv=%b re=%b rd=%h bus=%b%b%b required 1 0 %h 011",
                  a, rsp_valid, rsp_error, rsp_rdata, chipselect, write_n, read_n, exp);
      end
      cyc;
      @(negedge clk);
      checks++;
      if ({rsp_valid, cmd_ready} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL read_done a=%0d: got rv/rdy=%b%b required 01", a, rsp_valid, cmd_ready);
      end
   endtask

   task test_stall;
      wc0 = write_count;
      cyc; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 2'd0;
      cmd_wdata = 32'h12345678; rsp_ready = 1'b1; waitrequest = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         cyc; cmd_valid = 1'b0; waitrequest = (c <= 5);
         @(negedge clk);
         checks++;
         if ({chipselect, write_n, read_n, address, writedata, rsp_valid}
             !== {3'b101, 2'd0, 32'h12345678, 1'b0}) begin
            errors++;
            $display("[TB] FAIL stall_hold c=%0d: got cs/wn/rn=%b%b%b addr=%0d wd=%h rv=%b required 101 0 12345678 0",
                     c, chipselect, write_n, read_n, address, writedata, rsp_valid);
         end
      end
      cyc; waitrequest = 1'b0;
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_error, rsp_rdata, chipselect} !== {2'b10, 32'h0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL stall_rsp: got rv=%b re=%b rd=%h cs=%b required 1 0 0 0",
                  rsp_valid, rsp_error, rsp_rdata, chipselect);
      end
      checks++;
      if (pio_reg !== 32'h12345678 || write_count != wc0 + 1) begin
         errors++;
         $display("[TB] FAIL stall_landed: got reg=%h writes=%0d required 12345678 1",
                  pio_reg, write_count - wc0);
      end
   endtask

   task test_timeout;
      cyc; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 2'd0;
      cmd_wdata = 32'h0; rsp_ready = 1'b1; waitrequest = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         cyc; cmd_valid = 1'b0;
         @(negedge clk);
         checks++;
         if ({chipselect, write_n, read_n, rsp_valid} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL timeout_strobe c=%0d: got cs/wn/rn/rv=%b%b%b%b required 1100",
                     c, chipselect, write_n, read_n, rsp_valid);
         end
      end
      cyc;
      @(negedge clk);
      checks++;
      if ({chipselect, write_n, read_n, rsp_valid, rsp_error, rsp_rdata} !== {3'b011, 2'b11, 32'h0}) begin
         errors++;
         $display("[TB] FAIL timeout_rsp: got bus=%b%b%b rv=%b re=%b rd=%h required 011 1 1 0",
                  chipselect, write_n, read_n, rsp_valid, rsp_error, rsp_rdata);
      end
      waitrequest = 1'b0;
   endtask

   task test_backpressure;
      cyc; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 2'd0;
      cmd_wdata = 32'h0; rsp_ready = 1'b0; waitrequest = 1'b0;
      cyc; cmd_valid = 1'b0;
      for (int c = 2; c <= 11; c++) begin
         cyc; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_wdata = 32'hBAD0BAD0;
         @(negedge clk);
         checks++;
         if ({rsp_valid, rsp_rdata, cmd_ready, chipselect} !== {1'b1, 32'h12345678, 2'b00}) begin
            errors++;
            $display("[TB] FAIL backpressure_hold c=%0d: got rv=%b rd=%h rdy=%b cs=%b required 1 12345678 0 0",
                     c, rsp_valid, rsp_rdata, cmd_ready, chipselect);
         end
      end
      cyc; cmd_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL backpressure_release: got rv=%b required 1", rsp_valid);
      end
      cyc;
      @(negedge clk);
      checks++;
      if ({rsp_valid, cmd_ready} !== 2'b01 || pio_reg !== 32'h12345678) begin
         errors++;
         $display("[TB] FAIL backpressure_done: got rv/rdy=%b%b reg=%h required 01 12345678",
                  rsp_valid, cmd_ready, pio_reg);
      end
   endtask

   task test_reset_mid;
      wc0 = write_count;
      cyc; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_address = 2'd2;
      cmd_wdata = 32'h00000055; rsp_ready = 1'b1; waitrequest = 1'b0;
      cyc; cmd_valid = 1'b0;
      #1;
      checks++;
      if ({chipselect, write_n, read_n, address} !== {3'b101, 2'd2}) begin
         errors++;
         $display("[TB] FAIL midreset_pre: got cs/wn/rn=%b%b%b addr=%0d required 101 2",
                  chipselect, write_n, read_n, address);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({chipselect, write_n, read_n, address, writedata, rsp_valid, cmd_ready}
          !== {3'b011, 2'd0, 32'h0, 2'b01}) begin
         errors++;
         $display("[TB] FAIL midreset_async: got cs/wn/rn=%b%b%b addr=%0d wd=%h rv=%b rdy=%b required 011 0 0 0 1",
                  chipselect, write_n, read_n, address, writedata, rsp_valid, cmd_ready);
      end
      @(negedge clk);
      #2 reset_n = 1'b1;
      cyc;
      @(negedge clk);
      checks++;
      if ({cmd_ready, chipselect, rsp_valid} !== 3'b100 || write_count != wc0) begin
         errors++;
         $display("[TB] FAIL midreset_after: got rdy/cs/rv=%b%b%b writes=%0d required 100 0",
                  cmd_ready, chipselect, rsp_valid, write_count - wc0);
      end
   endtask

   task test_latency2;
      cyc; cmd_valid2 = 1'b1; cmd_write = 1'b0; cmd_address = 2'd3;
      cmd_wdata = 32'h0; rsp_ready = 1'b1; readdata2 = 32'hFFFFFFFF;
      cyc; cmd_valid2 = 1'b0; readdata2 = 32'h11111111;
      @(negedge clk);
      checks++;
      if ({chipselect2, write_n2, read_n2, address2, writedata2} !== {3'b110, 2'd3, 32'h0}) begin
         errors++;
         $display("[TB] FAIL lat2_strobe: got cs/wn/rn=%b%b%b addr=%0d wd=%h required 110 3 0",
                  chipselect2, write_n2, read_n2, address2, writedata2);
      end
      cyc; readdata2 = 32'h22222222;
      @(negedge clk);
      checks++;
      if ({chipselect2, write_n2, read_n2, rsp_valid2} !== 4'b0110) begin
         errors++;
         $display("[TB] FAIL lat2_wait1: got cs/wn/rn/rv=%b%b%b%b required 0110",
                  chipselect2, write_n2, read_n2, rsp_valid2);
      end
      cyc; readdata2 = 32'hA5A5A5A5;
      @(negedge clk);
      checks++;
      if (rsp_valid2 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL lat2_wait2: got rv=%b required 0", rsp_valid2);
      end
      cyc; readdata2 = 32'h33333333;
      @(negedge clk);
      checks++;
      if ({rsp_valid2, rsp_error2, rsp_rdata2} !== {2'b10, 32'hA5A5A5A5}) begin
         errors++;
         $display("[TB] FAIL lat2_rsp: got rv=%b re=%b rd=%h required 1 0 a5a5a5a5",
                  rsp_valid2, rsp_error2, rsp_rdata2);
      end
      cyc;
      @(negedge clk);
      checks++;
      if ({rsp_valid2, cmd_ready2} !== 2'b01) begin
         errors++;
         $display("[TB] FAIL lat2_done: got rv/rdy=%b%b required 01", rsp_valid2, cmd_ready2);
      end
   endtask

   // Scenario sequence; each step relies on the slave register contents
   // left by the previous one.
   initial begin
      test_reset;
      test_write;
      test_read(2'd0, 32'hDEADBEEF);
      test_read(2'd1, 32'h0);
      test_stall;
      test_timeout;
      test_read(2'd0, 32'h12345678);
      test_backpressure;
      test_latency2;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
